// File: rtl/serial_lut_pkg.sv
// Shared types and size helpers for the double-buffered serial LUT.
package serial_lut_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    COMMIT   = 2'd2,
    WAIT_REL = 2'd3
  } lut_state_e;

  function automatic int table_bits(
    input int in_w,
    input int out_w
  );
    return (1 << in_w) * out_w;
  endfunction

  function automatic int cnt_width(
    input int tbits
  );
    return $clog2(tbits + 1);
  endfunction

endpackage

// File: rtl/lut_frame_ctrl.sv
// Frame FSM for serial_lut_bank: counts serial bits, flags short
// frames and produces shift/commit strobes plus status pulses.
module lut_frame_ctrl
  import serial_lut_pkg::*;
#(
  parameter int TABLE_BITS = 48,
  parameter int CNT_W      = cnt_width(TABLE_BITS)
) (
  input  logic clk,
  input  logic rst,
  input  logic cs_n_i,
  output logic shift_en_o,
  output logic commit_en_o,
  output logic load_done_o,
  output logic load_err_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TABLE_BITS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  lut_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_en_o = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cs_n_i) begin
          shift_en_o = 1'b1;
          cnt_d      = ONE;
          state_d    = (LAST == ONE) ? COMMIT : SHIFT;
        end
      end
      SHIFT: begin
        if (cs_n_i) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          shift_en_o = 1'b1;
          cnt_d      = cnt_q + ONE;
          if (cnt_d == LAST) state_d = COMMIT;
        end
      end
      COMMIT: begin
        cnt_d   = '0;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (cs_n_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Status flags are registered from the next state so they
    // line up exactly with the state they describe.
    done_d = (state_d == COMMIT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign commit_en_o = (state_q == COMMIT);
  assign load_done_o = done_q;
  assign load_err_o  = err_q;
  assign busy_o      = busy_q;

endmodule

// File: rtl/serial_lut_bank.sv
// Double-buffered serial-load LUT with registered lookups.
// Optional shadow readback port dout: SERIAL_LUT_READBACK_EN.
module serial_lut_bank
  import serial_lut_pkg::*;
#(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d,
  input  logic                 cs_n,
  input  logic                 lookup_valid,
  input  logic [IN_WIDTH-1:0]  sel,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 load_done,
  output logic                 load_err,
  output logic                 busy
`ifdef SERIAL_LUT_READBACK_EN
  ,
  output logic                 dout
`endif
);

  localparam int TBITS = table_bits(IN_WIDTH, OUT_WIDTH);
  localparam int CNT_W = cnt_width(TBITS);

  logic                 shift_en;
  logic                 commit_en;
  logic [TBITS-1:0]     shadow_q, shadow_d;
  logic [TBITS-1:0]     active_q, active_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 out_valid_q;
  logic [OUT_WIDTH-1:0] entry;

  lut_frame_ctrl #(
    .TABLE_BITS (TBITS),
    .CNT_W      (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .cs_n_i      (cs_n),
    .shift_en_o  (shift_en),
    .commit_en_o (commit_en),
    .load_done_o (load_done),
    .load_err_o  (load_err),
    .busy_o      (busy)
  );

  assign entry = active_q[int'(sel)*OUT_WIDTH +: OUT_WIDTH];

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    out_d    = out_q;
    if (shift_en)     shadow_d = {shadow_q[TBITS-2:0], d};
    if (commit_en)    active_d = shadow_q;
    if (lookup_valid) out_d    = entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= '0;
      active_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      out_q       <= out_d;
      out_valid_q <= lookup_valid;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef SERIAL_LUT_READBACK_EN
  logic dout_q;

  // Old shadow bits fall out of the MSB as new ones enter.
  always_ff @(posedge clk) begin
    if (rst)           dout_q <= 1'b0;
    else if (shift_en) dout_q <= shadow_q[TBITS-1];
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_serial_lut_bank.sv
// Directed bench for serial_lut_bank (IN_WIDTH=2, OUT_WIDTH=3).
module tb_serial_lut_bank;

  localparam int IW = 2;
  localparam int OW = 3;

  typedef struct {
    int          phase;
    logic [1:0]  sel;
    logic [2:0]  exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          d;
  logic          cs_n;
  logic          lookup_valid;
  logic [IW-1:0] sel;
  logic          out_valid;
  logic [OW-1:0] out;
  logic          load_done;
  logic          load_err;
  logic          busy;
`ifdef SERIAL_LUT_READBACK_EN
  logic          dout;
`endif

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  vec_t tbl [20];

  localparam logic [11:0] T1 = 12'b111_110_101_100;
  localparam logic [11:0] T2 = 12'b001_110_101_100;
  localparam logic [11:0] T3 = 12'b010_011_000_111;
  localparam logic [11:0] T4 = 12'b101_001_110_010;

  serial_lut_bank #(
    .IN_WIDTH  (IW),
    .OUT_WIDTH (OW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .d            (d),
    .cs_n         (cs_n),
    .lookup_valid (lookup_valid),
    .sel          (sel),
    .out_valid    (out_valid),
    .out          (out),
    .load_done    (load_done),
    .load_err     (load_err),
    .busy         (busy)
`ifdef SERIAL_LUT_READBACK_EN
    ,
    .dout         (dout)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt++;
    if (load_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [1:0] s, input logic [2:0] e);
    lookup_valid = 1'b1;
    sel = s;
    tick();
    chk("lookup_vld", int'(out_valid), 1);
    chk("lookup_out", int'(out), int'(e));
    lookup_valid = 1'b0;
    tick();
    chk("idle_vld", int'(out_valid), 0);
    chk("idle_hold", int'(out), int'(e));
  endtask

  task automatic run_phase(input int p);
    for (int i = 0; i < 20; i++)
      if (tbl[i].phase == p) do_lookup(tbl[i].sel, tbl[i].exp);
  endtask

  task automatic shift_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cs_n = 1'b0;
      d = bits[i];
      tick();
    end
  endtask

  task automatic load(input logic [11:0] t);
    int d0;
    d0 = done_cnt;
    shift_bits({4'b0, t}, 12);
    chk("load_done_hi", int'(load_done), 1);
    cs_n = 1'b1;
    tick();
    chk("load_done_lo", int'(load_done), 0);
    chk("wait_busy", int'(busy), 1);
    tick();
    chk("idle_busy", int'(busy), 0);
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    logic [2:0] ex [5][4];
    int d0;
    int e0;
    ex = '{'{0, 0, 0, 0}, '{4, 5, 6, 7}, '{7, 0, 3, 2},
           '{2, 6, 1, 5}, '{0, 0, 0, 0}};
    for (int p = 0; p < 5; p++)
      for (int s = 0; s < 4; s++)
        tbl[p*4+s] = '{p, 2'(s), ex[p][s]};

    rst = 1'b1;
    d = 1'b0;
    cs_n = 1'b1;
    lookup_valid = 1'b0;
    sel = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out", int'(out), 0);
    chk("rst_vld", int'(out_valid), 0);
    chk("rst_done", int'(load_done), 0);
    chk("rst_err", int'(load_err), 0);
    chk("rst_busy", int'(busy), 0);
    run_phase(0);

    load(T1);
    run_phase(1);

    // Lookup every cycle across a commit: old value until the
    // COMMIT-cycle request, new value afterwards.
    lookup_valid = 1'b1;
    sel = 2'd3;
    for (int i = 11; i >= 0; i--) begin
      cs_n = 1'b0;
      d = T2[i];
      tick();
      chk("b2b_old", int'(out), 7);
    end
    chk("b2b_done", int'(load_done), 1);
    cs_n = 1'b1;
    tick();
    chk("b2b_commit_req", int'(out), 7);
    tick();
    chk("b2b_new", int'(out), 1);
    chk("b2b_busy", int'(busy), 0);
    lookup_valid = 1'b0;
    tick();

    d0 = done_cnt;
    e0 = err_cnt;
    shift_bits(16'h005a, 7);
    chk("abort_busy", int'(busy), 1);
    cs_n = 1'b1;
    tick();
    chk("abort_err_hi", int'(load_err), 1);
    chk("abort_no_done", int'(load_done), 0);
    tick();
    chk("abort_err_lo", int'(load_err), 0);
    chk("abort_busy_lo", int'(busy), 0);
    chk("abort_err_cnt", err_cnt - e0, 1);
    chk("abort_done_cnt", done_cnt - d0, 0);
    do_lookup(2'd1, 3'd5);
    load(T3);
    run_phase(2);

    d0 = done_cnt;
    shift_bits({1'b0, T4, 3'b111}, 15);
    chk("long_busy", int'(busy), 1);
    cs_n = 1'b1;
    tick();
    chk("long_busy_lo", int'(busy), 0);
    chk("long_done_cnt", done_cnt - d0, 1);
    run_phase(3);

    d0 = done_cnt;
    e0 = err_cnt;
    shift_bits({4'b0, T1}, 6);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    cs_n = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out", int'(out), 0);
    chk("mrst_vld", int'(out_valid), 0);
    chk("mrst_done", int'(load_done), 0);
    chk("mrst_err", int'(load_err), 0);
    chk("mrst_busy", int'(busy), 0);
`ifdef SERIAL_LUT_READBACK_EN
    chk("mrst_dout", int'(dout), 0);
`endif
    repeat (3) tick();
    chk("mrst_no_done", done_cnt - d0, 0);
    chk("mrst_no_err", err_cnt - e0, 0);
    run_phase(4);

    load(T1);
    for (int i = 11; i >= 0; i--) begin
      cs_n = 1'b0;
      d = T2[i];
      tick();
`ifdef SERIAL_LUT_READBACK_EN
      chk("dout_bit", int'(dout), int'(T1[i]));
`endif
    end
    chk("rb_done", int'(load_done), 1);
    cs_n = 1'b1;
    tick();
    tick();
    do_lookup(2'd3, 3'd1);
    do_lookup(2'd0, 3'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
